// File: rtl/sonata_pkg.sv
// Shared constants for the switch debouncer.
//
// Holds the default parameter values for switch_debounce and the bit
// positions of the switch fields on the 16-bit GPIO switch bus:
//   user  7:0   eight user slide switches
//   nav  12:8   five-way navigation joystick
//   sel 15:13   three select switches
package sonata_pkg;

   localparam int unsigned SwWidth       = 16;
   localparam int unsigned SwTickDiv     = 40000;  // 1 ms at 40 MHz
   localparam int unsigned SwStableTicks = 8;

   localparam int unsigned SwUserLsb = 0;
   localparam int unsigned SwUserMsb = 7;
   localparam int unsigned SwNavLsb  = 8;
   localparam int unsigned SwNavMsb  = 12;
   localparam int unsigned SwSelLsb  = 13;
   localparam int unsigned SwSelMsb  = 15;

   typedef struct packed {
      logic [SwSelMsb-SwSelLsb:0]   sel;
      logic [SwNavMsb-SwNavLsb:0]   nav;
      logic [SwUserMsb-SwUserLsb:0] user;
   } sw_fields_t;

endpackage

// File: rtl/debounce_bit.sv
// Single-switch debouncer slice.
//
// A raw switch level is synchronised through two flops, then compared with
// the accepted (stable) level. While they differ, the run counter advances
// on each sample tick; once the input has disagreed for StableTicks
// consecutive ticks the stable level takes the new value and a one-cycle
// rise or fall pulse is produced. Any cycle in which the input agrees with
// the stable level restarts the run.
//
// Ports:
//   clk_sys_i    system clock
//   rst_sys_ni   asynchronous active-low reset
//   sw_i         raw asynchronous switch level
//   tick_i       one-cycle sample strobe from the shared tick counter
//   sw_o         debounced level
//   rise_o       one-cycle pulse on an accepted 0->1 change
//   fall_o       one-cycle pulse on an accepted 1->0 change
//   edge_next_o  combinational: a pulse will be registered on the next edge
module debounce_bit
   import sonata_pkg::*;
#(
   parameter int unsigned StableTicks = SwStableTicks,
   parameter int unsigned RunW        = $clog2(StableTicks + 1),
   parameter logic        ResetBit    = 1'b0
) (
   input  logic clk_sys_i,
   input  logic rst_sys_ni,
   input  logic sw_i,
   input  logic tick_i,
   output logic sw_o,
   output logic rise_o,
   output logic fall_o,
   output logic edge_next_o
);

   localparam logic [RunW-1:0] RunLast = RunW'(StableTicks - 1);

   logic            sync1_q, sync1_d;
   logic            sync2_q, sync2_d;
   logic            stable_q, stable_d;
   logic [RunW-1:0] run_q, run_d;
   logic            rise_q, rise_d;
   logic            fall_q, fall_d;

   always_comb begin
      sync1_d  = sw_i;
      sync2_d  = sync1_q;
      stable_d = stable_q;
      run_d    = run_q;
      rise_d   = 1'b0;
      fall_d   = 1'b0;

      if (sync2_q == stable_q) begin
         // Agreement at any time, tick or not, abandons a partial run.
         run_d = '0;
      end else if (tick_i) begin
         if (run_q == RunLast) begin
            stable_d = sync2_q;
            run_d    = '0;
            rise_d   = sync2_q;
            fall_d   = ~sync2_q;
         end else begin
            run_d = run_q + RunW'(1);
         end
      end
   end

   always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
      if (!rst_sys_ni) begin
         sync1_q  <= ResetBit;
         sync2_q  <= ResetBit;
         stable_q <= ResetBit;
         run_q    <= '0;
         rise_q   <= 1'b0;
         fall_q   <= 1'b0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         stable_q <= stable_d;
         run_q    <= run_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
      end
   end

   assign sw_o        = stable_q;
   assign rise_o      = rise_q;
   assign fall_o      = fall_q;
   assign edge_next_o = rise_d | fall_d;

`ifndef SYNTHESIS
   // The run counter clears on the very tick that would take it past the
   // last value, so it can never reach StableTicks.
   run_bounded_a : assert property (@(posedge clk_sys_i) disable iff (!rst_sys_ni)
      run_q <= RunLast);
   rise_fall_excl_a : assert property (@(posedge clk_sys_i) disable iff (!rst_sys_ni)
      !(rise_q && fall_q));
`endif

endmodule

// File: rtl/switch_debounce.sv
// Debouncer for the board's switch bank.
//
// A single free-running tick counter divides clk_sys_i down to the sample
// rate and is shared by Width independent debounce_bit slices. changed_o is
// registered from the slices' next-pulse terms so it lines up with
// rise_o/fall_o in the same cycle.
//
// Ports:
//   clk_sys_i   system clock, the only clock
//   rst_sys_ni  asynchronous active-low reset
//   sw_i        raw switch levels, 1 = on
//   sw_o        debounced switch levels
//   rise_o      per-bit one-cycle pulse on accepted 0->1
//   fall_o      per-bit one-cycle pulse on accepted 1->0
//   changed_o   one-cycle pulse when any bit rises or falls
module switch_debounce
   import sonata_pkg::*;
#(
   parameter int unsigned      Width       = SwWidth,
   parameter int unsigned      TickDiv     = SwTickDiv,
   parameter int unsigned      StableTicks = SwStableTicks,
   parameter logic [Width-1:0] ResetValue  = '0
) (
   input  logic             clk_sys_i,
   input  logic             rst_sys_ni,
   input  logic [Width-1:0] sw_i,
   output logic [Width-1:0] sw_o,
   output logic [Width-1:0] rise_o,
   output logic [Width-1:0] fall_o,
   output logic             changed_o
);

   localparam int unsigned     CntW     = $clog2(TickDiv);
   localparam logic [CntW-1:0] CntLast  = CntW'(TickDiv - 1);

   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             tick;
   logic             changed_q, changed_d;
   logic [Width-1:0] edge_next;

   always_comb begin
      tick  = (cnt_q == CntLast);
      cnt_d = tick ? '0 : cnt_q + CntW'(1);
   end

   always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
      if (!rst_sys_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   for (genvar i = 0; i < Width; i++) begin : g_bit
      debounce_bit #(
         .StableTicks (StableTicks),
         .ResetBit    (ResetValue[i])
      ) u_bit (
         .clk_sys_i   (clk_sys_i),
         .rst_sys_ni  (rst_sys_ni),
         .sw_i        (sw_i[i]),
         .tick_i      (tick),
         .sw_o        (sw_o[i]),
         .rise_o      (rise_o[i]),
         .fall_o      (fall_o[i]),
         .edge_next_o (edge_next[i])
      );
   end

   always_comb begin
      changed_d = |edge_next;
   end

   always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
      if (!rst_sys_ni) begin
         changed_q <= 1'b0;
      end else begin
         changed_q <= changed_d;
      end
   end

   assign changed_o = changed_q;

endmodule

// File: doc/switch_debounce.md
SWITCH_DEBOUNCE -- requirements
Module: switch_debounce

Interface
REQ-001 Parameter Width, default 16: number of switch inputs (8 user + 5 nav + 3 select).
REQ-002 Parameter TickDiv, default 40000: clk_sys_i cycles per sample tick (1 ms at 40 MHz); legal range 2 or more.
REQ-003 Parameter StableTicks, default 8: consecutive ticks an input must hold a new level before it is accepted; legal range 2 to 255.
REQ-004 Parameter ResetValue, default all-zero, Width bits: reset level of the synchronisers and of sw_o.
REQ-005 clk_sys_i  input  1  system clock; the only clock.
REQ-006 rst_sys_ni  input  1  asynchronous, active-low reset.
REQ-007 sw_i  input  Width  raw, asynchronous, already-inverted switch levels (1 = on).
REQ-008 sw_o  output  Width  debounced switch levels, feeding the GPIO input bus.
REQ-009 rise_o  output  Width  one-cycle pulse per bit when sw_o goes 0 to 1.
REQ-010 fall_o  output  Width  one-cycle pulse per bit when sw_o goes 1 to 0.
REQ-011 changed_o  output  1  OR-reduction of rise_o and fall_o, registered in the same cycle as them.

Function
REQ-012 Each sw_i bit SHALL pass through a 2-flop synchroniser; the synchronised level (sync) is valid 2 cycles after an sw_i change.
REQ-013 A shared tick counter SHALL count 0 to TickDiv-1 and wrap; tick is asserted for one cycle when the count equals TickDiv-1.
REQ-014 Per-bit state: stable level (the sw_o bit) and a run counter, $clog2(StableTicks+1) bits wide.
REQ-015 sync == stable in a cycle: run counter SHALL clear to 0 in that cycle, regardless of tick.
REQ-016 sync != stable with tick, and run counter < StableTicks-1: run counter SHALL increment by 1.
REQ-017 sync != stable with tick, and run counter == StableTicks-1: on the next edge, the stable bit SHALL take the sync value and the run counter SHALL clear.
REQ-018 On the edge where the stable bit updates, rise_o or fall_o (by direction) and changed_o SHALL assert for exactly one cycle.
REQ-019 A glitch shorter than the tick period that returns before any tick occurs SHALL clear the run counter and cause no output change.
REQ-020 Bits are fully independent; several bits may update in the same cycle, each with its own pulse.
REQ-021 rise_o and fall_o for the same bit SHALL never assert together, and a bit SHALL never pulse on consecutive cycles.
REQ-022 Acceptance latency SHALL be at most 2 + StableTicks*TickDiv + 1 cycles from a clean sw_i edge.
REQ-023 The run counter SHALL never exceed StableTicks-1 (saturation is impossible by construction; asserted in simulation).

Reset
REQ-024 Asserting rst_sys_ni low SHALL immediately force all of the following, without a clock edge: synchronisers and sw_o = ResetValue, run and tick counters = 0, rise_o/fall_o/changed_o = 0.
REQ-025 Reset mid-count SHALL discard partial runs; after release, no pulse occurs unless the input then differs from ResetValue for a full StableTicks run.

Structure
REQ-026 Default parameter values and the switch-field bit positions (user 7:0, nav 12:8, sel 15:13) SHALL live in sonata_pkg.
REQ-027 Per-bit logic SHALL be one sub-module, debounce_bit (synchroniser, run counter, stable flop, edge pulses), generated Width times; the tick counter stays in switch_debounce.

Verification (TickDiv=4, StableTicks=3, Width=16, ResetValue=0)
REQ-028 Scenario: set sw_i[0]=1 and hold -> sw_o[0]=1 and rise_o[0] single pulse within 2+12+1 = 15 cycles; no other bit moves.
REQ-029 Scenario: pulse sw_i[3] high for 3 cycles, placed between ticks -> sw_o[3] stays 0; rise_o, fall_o and changed_o stay 0.
REQ-030 Scenario: toggle sw_i[5] every 6 cycles for 100 cycles -> no acceptance and no pulses; then hold sw_i[5]=1 -> accepted within 15 cycles.
REQ-031 Scenario: set sw_i=16'hFFFF simultaneously -> all sw_o bits update in the same cycle; rise_o=16'hFFFF for one cycle; changed_o one pulse.
REQ-032 Scenario: bit at 1, drive it to 0 and hold -> fall_o single pulse; rise_o never asserts.
REQ-033 Scenario: assert rst_sys_ni after 2 ticks of a pending run, with sw_i held at 1 -> sw_o is 0 immediately; after release, accepted only after a full new run of 15 cycles.
